// File: rtl/regfile_pkg.sv
// Shared definitions for the parameterised register file: default sizing
// and the flush-sequencer state encoding.
package regfile_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int DEPTH_DEF    = 32;
    localparam int ZERO_REG_DEF = 1;

    // Flush sequencer: IDLE accepts writes, DRAIN lets the pending write
    // land, SWEEP clears one register per cycle.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        SWEEP = 2'd2
    } state_e;

endpackage

// File: rtl/regfile_param_rd.sv
// One read port: forwards the pending write when it targets this address,
// otherwise returns the array word; forces 0 during a flush and for the
// hard-wired zero register.
module rf_read_port #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] arr_data,
    input  logic              pend_valid,
    input  logic [ADDR_W-1:0] pend_addr,
    input  logic [DATA_W-1:0] pend_data,
    input  logic              busy,
    output logic [DATA_W-1:0] rd_data
);

    logic zero_addr;
    logic hit;

    // Bypass compare and output select; zero-register and flush gating win.
    always_comb begin
        zero_addr = (ZERO_REG != 0) && (rd_addr == '0);
        hit       = pend_valid && (pend_addr == rd_addr);
        rd_data   = arr_data;
        if (busy || zero_addr) begin
            rd_data = '0;
        end else if (hit) begin
            rd_data = pend_data;
        end
    end

endmodule

// File: rtl/regfile_param.sv
// Parameterised 2-read / 1-write register file with a one-deep write
// pipeline (pending entry forwarded to the read ports) and a flush
// sequencer that clears every register one index per cycle.
module regfile_param
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int ZERO_REG = ZERO_REG_DEF
) (
    input  logic                     clk,
    input  logic                     clrn,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_a,
    output logic [DATA_W-1:0]        rd_data_a,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_b,
    output logic [DATA_W-1:0]        rd_data_b,
    input  logic                     flush_req,
    output logic                     flush_busy
);

    localparam int ADDR_W = $clog2(DEPTH);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                pend_valid_q, pend_valid_d;
    logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
    logic [DATA_W-1:0]   pend_data_q, pend_data_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   mem_d [DEPTH];
    logic                busy;
    logic                commit_en;

    // Busy flag and commit qualifier; writes to a hard-wired zero register are dropped.
    always_comb begin
        busy       = (state_q != IDLE);
        flush_busy = busy;
        commit_en  = pend_valid_q && !((ZERO_REG != 0) && (pend_addr_q == '0));
    end

    // Flush sequencer next state and sweep counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (flush_req) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                cnt_d   = '0;
                state_d = SWEEP;
            end
            SWEEP: begin
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Write capture: a new request is taken only when no flush is running.
    always_comb begin
        pend_valid_d = wr_en && !busy;
        pend_addr_d  = pend_addr_q;
        pend_data_d  = pend_data_q;
        if (pend_valid_d) begin
            pend_addr_d = wr_addr;
            pend_data_d = wr_data;
        end
    end

    // Array update: commit the pending entry, then apply the sweep clear.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (commit_en && (pend_addr_q == ADDR_W'(i))) begin
                mem_d[i] = pend_data_q;
            end
            if ((state_q == SWEEP) && (cnt_q == ADDR_W'(i))) begin
                mem_d[i] = '0;
            end
        end
    end

    // State registers with asynchronous clear of everything.
    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            pend_data_q  <= pend_data_d;
            mem_q        <= mem_d;
        end
    end

    rf_read_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_rd_a (
        .rd_addr    (rd_addr_a),
        .arr_data   (mem_q[rd_addr_a]),
        .pend_valid (pend_valid_q),
        .pend_addr  (pend_addr_q),
        .pend_data  (pend_data_q),
        .busy       (busy),
        .rd_data    (rd_data_a)
    );

    rf_read_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_rd_b (
        .rd_addr    (rd_addr_b),
        .arr_data   (mem_q[rd_addr_b]),
        .pend_valid (pend_valid_q),
        .pend_addr  (pend_addr_q),
        .pend_data  (pend_data_q),
        .busy       (busy),
        .rd_data    (rd_data_b)
    );

endmodule

// File: tb/tb_regfile_param.sv
// Scoreboard bench for regfile_param: a driver applies stimulus on the
// falling edge and queues the expected read-port/busy values computed by a
// behavioural model; a monitor pops and compares a little later each cycle.
module tb_regfile_param;

    localparam int DW  = 32;
    localparam int DEP = 32;
    localparam int AW  = 5;

    logic          clk = 1'b0;
    logic          clrn = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [AW-1:0] rd_addr_a = '0;
    logic [DW-1:0] rd_data_a;
    logic [AW-1:0] rd_addr_b = '0;
    logic [DW-1:0] rd_data_b;
    logic          flush_req = 1'b0;
    logic          flush_busy;

    regfile_param #(.DATA_W(DW), .DEPTH(DEP), .ZERO_REG(1)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_addr_a  (rd_addr_a),
        .rd_data_a  (rd_data_a),
        .rd_addr_b  (rd_addr_b),
        .rd_data_b  (rd_data_b),
        .flush_req  (flush_req),
        .flush_busy (flush_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] aa;
        logic [AW-1:0] ab;
        logic [DW-1:0] ea;
        logic [DW-1:0] eb;
        logic          ebusy;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   drv_done = 1'b0;

    // Behavioural model: register contents, the one in-flight write, and the
    // number of busy cycles still to run in the current flush.
    logic [DW-1:0] m_mem [DEP];
    bit            m_pv;
    int            m_pa;
    logic [DW-1:0] m_pd;
    int            m_flush;

    function automatic logic [DW-1:0] exp_read(input int addr);
        if (clrn || m_flush > 0 || addr == 0) return '0;
        if (m_pv && m_pa == addr) return m_pd;
        return m_mem[addr];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEP; i++) m_mem[i] = '0;
        m_pv = 1'b0;
        m_pa = 0;
        m_pd = '0;
        m_flush = 0;
    endtask

    task automatic model_edge(input bit we, input int wa, input logic [DW-1:0] wd, input bit fl);
        bit was_busy;
        was_busy = (m_flush > 0);
        if (m_pv && m_pa != 0) m_mem[m_pa] = m_pd;
        if (was_busy && m_flush <= DEP) m_mem[DEP - m_flush] = '0;
        m_pv = we && !was_busy;
        if (m_pv) begin
            m_pa = wa;
            m_pd = wd;
        end
        if (was_busy) m_flush--;
        else if (fl) m_flush = DEP + 1;
    endtask

    task automatic cycle(input bit rst, input bit we, input logic [AW-1:0] wa,
                         input logic [DW-1:0] wd, input logic [AW-1:0] ra,
                         input logic [AW-1:0] rb, input bit fl);
        exp_t e;
        @(negedge clk);
        clrn      = rst;
        wr_en     = we;
        wr_addr   = wa;
        wr_data   = wd;
        rd_addr_a = ra;
        rd_addr_b = rb;
        flush_req = fl;
        if (rst) model_reset();
        e.aa    = ra;
        e.ab    = rb;
        e.ea    = exp_read(int'(ra));
        e.eb    = exp_read(int'(rb));
        e.ebusy = !rst && (m_flush > 0);
        q.push_back(e);
        if (!rst) model_edge(we, int'(wa), wd, fl);
    endtask

    task automatic idle(input logic [AW-1:0] ra, input logic [AW-1:0] rb);
        cycle(1'b0, 1'b0, '0, '0, ra, rb, 1'b0);
    endtask

    // Monitor: compare every queued expectation against the settled outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (rd_data_a !== e.ea) begin
                    errors++;
                    $display("FAIL rd_a[%0d] got %h want %h at %0t", e.aa, rd_data_a, e.ea, $time);
                end
                checks++;
                if (rd_data_b !== e.eb) begin
                    errors++;
                    $display("FAIL rd_b[%0d] got %h want %h at %0t", e.ab, rd_data_b, e.eb, $time);
                end
                checks++;
                if (flush_busy !== e.ebusy) begin
                    errors++;
                    $display("FAIL flush_busy got %b want %b at %0t", flush_busy, e.ebusy, $time);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog timeout CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    // Driver: directed scenarios followed by randomized traffic.
    initial begin
        logic [AW-1:0] ra, rb, wa;
        int guard;
        model_reset();

        // Reset: every index reads 0 on both ports.
        cycle(1'b1, 1'b0, '0, '0, '0, '0, 1'b0);
        for (int i = 0; i < DEP; i++) idle(AW'(i), AW'(DEP - 1 - i));

        // Bypass: pre-write value, forwarded value, then array value.
        cycle(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, 1'b0);
        idle(5'd5, 5'd4);
        idle(5'd5, 5'd5);

        // Zero register ignores writes.
        cycle(1'b0, 1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0, 1'b0);
        for (int i = 0; i < 3; i++) idle(5'd0, 5'd0);

        // Back-to-back writes.
        cycle(1'b0, 1'b1, 5'd3, 32'd1, 5'd3, 5'd7, 1'b0);
        cycle(1'b0, 1'b1, 5'd3, 32'd2, 5'd3, 5'd7, 1'b0);
        cycle(1'b0, 1'b1, 5'd7, 32'd3, 5'd3, 5'd7, 1'b0);
        idle(5'd3, 5'd7);
        idle(5'd3, 5'd7);

        // Flush with a same-edge write and writes/requests during busy.
        for (int i = 1; i < DEP; i++) cycle(1'b0, 1'b1, AW'(i), DW'(i), AW'(i), AW'(i - 1), 1'b0);
        cycle(1'b0, 1'b1, 5'd9, 32'hAA, 5'd9, 5'd1, 1'b1);
        for (int i = 0; i < DEP + 1; i++) begin
            wa = AW'($urandom_range(1, DEP - 1));
            cycle(1'b0, 1'b1, wa, $urandom, wa, AW'($urandom), 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < DEP; i++) idle(AW'(i), AW'(DEP - 1 - i));

        // Reset in the middle of a sweep, then a normal write.
        for (int i = 1; i < DEP; i++) cycle(1'b0, 1'b1, AW'(i), ~DW'(i), 5'd0, 5'd0, 1'b0);
        cycle(1'b0, 1'b0, '0, '0, 5'd2, 5'd3, 1'b1);
        guard = 0;
        while (m_flush != DEP - 10 && guard < 60) begin
            idle(5'd10, 5'd11);
            guard++;
        end
        cycle(1'b1, 1'b1, 5'd12, 32'h1, 5'd10, 5'd12, 1'b0);
        for (int i = 0; i < DEP; i++) idle(AW'(i), AW'(DEP - 1 - i));
        cycle(1'b0, 1'b1, 5'd4, 32'h55, 5'd4, 5'd4, 1'b0);
        idle(5'd4, 5'd4);
        idle(5'd4, 5'd0);

        // Randomized traffic, addresses biased toward recent writes.
        for (int n = 0; n < 900; n++) begin
            wa = AW'($urandom);
            ra = ($urandom_range(0, 2) == 0) ? AW'(m_pa) : AW'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : AW'($urandom);
            cycle(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)), wa, $urandom,
                  ra, rb, ($urandom_range(0, 39) == 0));
        end
        for (int i = 0; i < DEP; i++) idle(AW'(i), AW'(i));

        repeat (2) @(negedge clk);
        #4;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d entries want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, word width in bits (>=1).
REQ-002 The block SHALL have parameter DEPTH, default 32, number of registers (power of two, >=4).
REQ-003 The block SHALL have parameter ZERO_REG, default 1: 1 means register 0 reads 0 and ignores writes; 0 means register 0 is an ordinary register.
REQ-004 The block SHALL derive ADDR_W = log2(DEPTH) as a localparam.
REQ-005 Reset clrn is asynchronous and active-high; clock is clk.
REQ-006 clk  input  1  clock; all state updates on the rising edge.
REQ-007 clrn  input  1  asynchronous active-high clear of all state.
REQ-008 wr_en  input  1  write request, sampled each rising edge.
REQ-009 wr_addr  input  ADDR_W  write register index.
REQ-010 wr_data  input  DATA_W  write data.
REQ-011 rd_addr_a  input  ADDR_W  read port A index.
REQ-012 rd_data_a  output  DATA_W  read port A data, combinational from rd_addr_a and state.
REQ-013 rd_addr_b  input  ADDR_W  read port B index.
REQ-014 rd_data_b  output  DATA_W  read port B data, combinational from rd_addr_b and state.
REQ-015 flush_req  input  1  request to zero all registers, sampled each rising edge.
REQ-016 flush_busy  output  1  high while a flush is in progress.

Function
REQ-017 A write SHALL be a two-stage pipeline: at edge N, wr_en=1 with flush_busy=0 loads pend_valid/pend_addr/pend_data; at edge N+1 the pending entry commits to the array.
REQ-018 When wr_en=0 or flush_busy=1 at an edge, pend_valid SHALL go 0 at that edge; the pending entry at that edge SHALL still commit.
REQ-019 A write to index 0 with ZERO_REG=1 SHALL be dropped at commit and never forwarded.
REQ-020 Each read port SHALL return pend_data when pend_valid=1, pend_addr equals the port address, and the address is not a zero register; otherwise it SHALL return array[addr].
REQ-021 Same-cycle wr_en/rd_addr match SHALL NOT be forwarded: the read returns the pre-write value until the capturing edge.
REQ-022 Both read ports SHALL operate independently; identical addresses SHALL return identical data.
REQ-023 The FSM SHALL have states IDLE, DRAIN and SWEEP.
REQ-024 IDLE: flush_req=1 at an edge SHALL move to DRAIN; the pending entry and any write captured at that same edge SHALL be processed normally.
REQ-025 DRAIN: lasts 1 cycle; the pending entry commits; the sweep counter loads 0; then the FSM moves to SWEEP.
REQ-026 SWEEP: each edge writes 0 to array[counter] and increments the counter; after index DEPTH-1 the FSM returns to IDLE.
REQ-027 The counter SHALL be ADDR_W bits wide; wrap to 0 coincides with the exit from SWEEP.
REQ-028 flush_busy SHALL be high in DRAIN and SWEEP, i.e. exactly DEPTH+1 cycles per flush.
REQ-029 While flush_busy=1, wr_en and flush_req SHALL be ignored, and rd_data_a/rd_data_b SHALL read 0.

Reset
REQ-030 clrn=1 SHALL asynchronously zero all array entries, pend_valid, pend_addr, pend_data and the sweep counter, and force IDLE; flush_busy, rd_data_a and rd_data_b SHALL then read 0.
REQ-031 clrn asserted mid-flush or mid-write SHALL abort the operation; no write completes after clrn is released until a new wr_en is sampled.

Structure
REQ-032 Package regfile_pkg SHALL hold the FSM state enum (IDLE/DRAIN/SWEEP) and the parameter defaults.
REQ-033 A single sub-module rf_read_port (bypass compare plus mux plus busy/zero gating) SHALL be instantiated twice, once per read port.

Verification (DATA_W=32, DEPTH=32, ZERO_REG=1)
REQ-034 Reset: pulse clrn, read all 32 indices on both ports -> every read 0 and flush_busy=0.
REQ-035 Bypass: write 0xDEADBEEF to r5 at edge N, rd_addr_a=5 -> 0x0 before edge N, 0xDEADBEEF from edge N on (forwarded), 0xDEADBEEF after edge N+1 from the array.
REQ-036 Zero register: write 0x12345678 to r0 -> rd_data_a and rd_data_b at address 0 stay 0 on every cycle.
REQ-037 Back-to-back writes: r3=1, r3=2, r7=3 on consecutive edges with rd_addr_a=3 and rd_addr_b=7 -> A reads 1, then 2 and holds 2; B reads 3 from the third edge.
REQ-038 Flush: load r1..r31 with their index, assert flush_req with a same-edge write r9=0xAA -> flush_busy high exactly 33 cycles, reads 0 during flush, all registers 0 afterwards, wr_en during busy has no effect.
REQ-039 Reset mid-flush: assert clrn at sweep index 10 -> immediate IDLE, flush_busy=0, all registers 0; a write after release commits normally.
